// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's memory-client port, execute-stage instruction port and redirect request.
// The fetch unit is the master; the host memory, the consumer and the redirect source are the slave side.
interface fetch_unit_if;
  logic [2:0]  cCommand;
  logic [31:0] cAddress;
  logic [31:0] cData;
  logic        hReady;
  logic        hSignal;
  logic [31:0] hData;

  // Valid/ready rule: an instruction moves on a clock edge where both instValid and instReady
  // are 1. instValid and the payload come only from registers and stay put until that transfer;
  // instReady may change freely. A redirect in the same cycle cancels the transfer.
  logic        instValid;
  logic        instReady;
  logic [31:0] instData;
  logic [31:0] instPC;
  logic        instFault;

  logic        redirectValid;
  logic [31:0] redirectPC;

  modport master (
    output cCommand, cAddress, cData, instValid, instData, instPC, instFault,
    input  hReady, hSignal, hData, instReady, redirectValid, redirectPC
  );

  modport slave (
    input  cCommand, cAddress, cData, instValid, instData, instPC, instFault,
    output hReady, hSignal, hData, instReady, redirectValid, redirectPC
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: one outstanding word read, a DEPTH-entry prefetch queue,
// branch redirect with flush, and fault entries for bus errors and misaligned PCs.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h800,
  parameter int          DEPTH       = 4,
  parameter int          COUNT_WIDTH = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  fetch_unit_if.master           bus,
  output logic [1:0]             state,
  output logic [COUNT_WIDTH-1:0] tickCount
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] MemoryInterfaceCommandNOP      = 3'd0;
  localparam logic [2:0] MemoryInterfaceCommandReadWord = 3'd1;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  fetch_state_t            fsm;
  logic [31:0]             pc;
  logic [2:0]              command;
  logic [31:0]             address;
  logic                    discard;
  logic [COUNT_WIDTH-1:0]  ticks;

  logic [31:0]             q_pc   [DEPTH];
  logic [31:0]             q_data [DEPTH];
  logic [DEPTH-1:0]        q_fault;
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [CNT_W-1:0]        count;

  logic                    redirect;
  logic                    completion;
  logic                    has_room;
  logic                    pop;
  logic                    push;
  logic [31:0]             push_pc;
  logic [31:0]             push_data;
  logic                    push_fault;

  always_comb begin
    redirect   = bus.redirectValid && (fsm != INIT);
    completion = (fsm == WAIT) && bus.hReady;
    // count never exceeds DEPTH, a power of two, so its top bit is set only when full.
    has_room   = !count[CNT_W-1];
    pop        = (count != '0) && bus.instReady && !redirect;
    push       = 1'b0;
    push_pc    = pc;
    push_data  = bus.hData;
    push_fault = bus.hSignal;
    if (!redirect) begin
      if ((fsm == ISSUE) && (pc[1:0] != 2'b00) && has_room) begin
        push       = 1'b1;
        push_data  = 32'd0;
        push_fault = 1'b1;
      end else if (completion && !discard) begin
        push = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_pc[wr_ptr]    <= push_pc;
      q_data[wr_ptr]  <= push_data;
      q_fault[wr_ptr] <= push_fault;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm     <= INIT;
      pc      <= RESET_PC;
      command <= MemoryInterfaceCommandNOP;
      address <= 32'd0;
      discard <= 1'b0;
      ticks   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      ticks <= (fsm == INIT) ? '0 : ticks + COUNT_WIDTH'(1);

      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end

      case (fsm)
        INIT: begin
          pc      <= RESET_PC;
          command <= MemoryInterfaceCommandNOP;
          fsm     <= ISSUE;
        end
        ISSUE: begin
          if (redirect) begin
            pc <= bus.redirectPC;
          end else if (pc[1:0] == 2'b00) begin
            if ((command == MemoryInterfaceCommandNOP) && bus.hReady && has_room) begin
              address <= pc;
              command <= MemoryInterfaceCommandReadWord;
              fsm     <= WAIT;
            end
          end else if (has_room) begin
            fsm <= HALT;
          end
        end
        WAIT: begin
          if (redirect) begin
            pc <= bus.redirectPC;
            if (bus.hReady) begin
              command <= MemoryInterfaceCommandNOP;
              discard <= 1'b0;
              fsm     <= ISSUE;
            end else begin
              // The read already on the bus belongs to the old stream; swallow it when it lands.
              discard <= 1'b1;
            end
          end else if (bus.hReady) begin
            command <= MemoryInterfaceCommandNOP;
            discard <= 1'b0;
            if (discard) begin
              fsm <= ISSUE;
            end else if (bus.hSignal) begin
              fsm <= HALT;
            end else begin
              pc  <= pc + 32'd4;
              fsm <= ISSUE;
            end
          end
        end
        HALT: begin
          if (redirect) begin
            pc  <= bus.redirectPC;
            fsm <= ISSUE;
          end
        end
        default: fsm <= INIT;
      endcase
    end
  end

  assign bus.cCommand  = command;
  assign bus.cAddress  = address;
  assign bus.cData     = 32'd0;
  assign bus.instValid = (count != '0);
  assign bus.instPC    = q_pc[rd_ptr];
  assign bus.instData  = q_data[rd_ptr];
  assign bus.instFault = q_fault[rd_ptr];
  assign state         = fsm;
  assign tickCount     = ticks;
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the RV32 core. It drives the core memory-interface client port with word reads and prefetches sequential instructions into a DEPTH-entry queue. It hands {pc, word, fault} to the execute stage over a valid/ready handshake. Compared with the single-fetch core loop, it adds a configurable reset vector, a prefetch queue, branch redirect with flush, fetch-fault reporting and a configurable-width cycle counter.

## Interface
- RESET_PC, 'h800, PC loaded in the INIT state
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- COUNT_WIDTH, 64, tickCount width
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- cCommand  out  3  memory command; only `MemoryInterfaceCommandNOP` / `MemoryInterfaceCommandReadWord` are driven
- cAddress  out  32  read address
- cData  out  32  write data; constant 0
- hReady  in  1  host ready / read-complete strobe
- hSignal  in  1  host error flag, sampled on read completion
- hData  in  32  read data, sampled on read completion
- instValid  out  1  queue head valid
- instReady  in  1  consumer accepts head
- instData  out  32  head instruction word (0 for a misalignment fault)
- instPC  out  32  head PC
- instFault  out  1  head is a fetch fault (bus error or misaligned PC)
- redirectValid  in  1  flush the queue and restart fetch at redirectPC
- redirectPC  in  32  new fetch PC
- state  out  2  INIT=0, ISSUE=1, WAIT=2, HALT=3
- tickCount  out  COUNT_WIDTH  cycles since leaving INIT

## Operation
- Reset values: state INIT, cCommand NOP, cAddress 0, cData 0, queue empty (instValid 0), discard 0, tickCount 0. PC is loaded in INIT.
- INIT: PC<=RESET_PC; cCommand<=NOP; next state ISSUE.
- ISSUE, PC[1:0]==0: when cCommand==NOP, hReady==1 and queue count<DEPTH: cAddress<=PC, cCommand<=ReadWord, next state WAIT.
- ISSUE, PC[1:0]!=0: when count<DEPTH, push {PC, 0, fault=1} with no memory access; next state HALT.
- WAIT: on hReady==1:
  - cCommand<=NOP.
  - If discard==1: drop the data, clear discard, go to ISSUE.
  - Else push {PC, hData, hSignal}.
  - hSignal==0: PC<=PC+4 (mod 2^32), go to ISSUE.
  - hSignal==1: go to HALT.
- HALT: no memory accesses; the queue still drains; exits only on redirect.
- Redirect (any state except INIT):
  - Queue flushed; PC<=redirectPC.
  - If in WAIT with no completion this cycle: discard<=1, stay in WAIT.
  - Otherwise: go to ISSUE, and any completion this cycle is dropped.
- Queue: circular buffer with read/write pointers of log2(DEPTH) bits (wrap naturally) and a count of log2(DEPTH)+1 bits. Pop when instValid && instReady. Push and pop may occur in the same cycle; count is unchanged.
- Only one read is ever in flight. The count<DEPTH check at issue guarantees a push never overflows.
- tickCount: 0 while in INIT, else +1 per cycle, wrapping modulo 2^COUNT_WIDTH.

## Timing
- instValid, instData, instPC, instFault are driven from registers: count!=0 and the head entry. No combinational path from the inputs.
- A push is visible on instValid the cycle after the completion edge.
- Minimum latency from reset release: INIT (1) → ISSUE (ReadWord driven next edge) → completion edge → instValid. First instruction appears 3 edges after reset drops, given hReady=1 throughout.
- Sustained throughput: one word per 2 cycles with a zero-wait host.
- Simultaneous events:
  - Redirect and pop in the same cycle: redirect wins; the pop is ignored.
  - Redirect and completion in the same cycle: data dropped, next state ISSUE, discard stays 0.
  - Reset mid-WAIT: cCommand returns to NOP next edge; the host is responsible for abandoning the read.
- redirectValid in INIT is ignored.

## Test plan
- Zero-wait memory containing word k = 'h1000+k at address 'h800+4k; consumer always ready. Required: first instValid 3 cycles after reset; instPC 'h800, 'h804, 'h808… with matching data; cAddress toggles every 2 cycles.
- Consumer stalled (instReady=0), DEPTH=4. Required: exactly 4 reads issued, then cCommand holds NOP; releasing instReady resumes fetch at PC 'h810.
- Redirect to 'h2000 during WAIT with hReady held low 3 cycles. Required: the late completion is dropped, the queue is empty, the next ReadWord goes to 'h2000, and the first delivered instPC is 'h2000.
- hSignal=1 on the read of 'h808. Required: entry {PC 'h808, fault 1} delivered, no further ReadWord; redirect to 'h800 restarts fetch.
- Redirect to 'h2002. Required: no memory access, one entry {PC 'h2002, data 0, fault 1}, state HALT.
- Reset asserted mid-WAIT. Required: cCommand NOP, instValid 0, tickCount 0 the next cycle; fetch restarts at RESET_PC.
